// File: rtl/restoring_divider8_pkg.sv
`default_nettype none
//============================================================================
// Module   : restoring_divider8_pkg
// Brief    : Shared state encoding and sizing constants for the divider
// Revision : 1.0 - initial release
//============================================================================
package restoring_divider8_pkg;

    localparam int DIV_WIDTH = 8;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int CNT_WIDTH = cnt_width(DIV_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/restoring_divider8_trial_subtractor.sv
`default_nettype none
//============================================================================
// Module   : trial_subtractor
// Brief    : Conditional-sum subtractor, diff = a + ~b + 1, borrow = ~carry_out
// Revision : 1.0 - initial release
//============================================================================
module trial_subtractor
    import restoring_divider8_pkg::*;
#(
    parameter int N = DIV_WIDTH + 1
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] b_inv;
    logic [N-1:0] sum_c0;
    logic [N-1:0] sum_c1;
    logic [N-1:0] cy_c0;
    logic [N-1:0] cy_c1;
    logic [N:0]   carry;

    // Both carry-in hypotheses are formed per bit; the real carry only steers muxes.
    assign b_inv  = ~b;
    assign sum_c0 = a ^ b_inv;
    assign sum_c1 = ~sum_c0;
    assign cy_c0  = a & b_inv;
    assign cy_c1  = a | b_inv;
    assign carry[0] = 1'b1;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_bit
            assign diff[i]    = carry[i] ? sum_c1[i] : sum_c0[i];
            assign carry[i+1] = carry[i] ? cy_c1[i]  : cy_c0[i];
        end
    endgenerate

    assign borrow = ~carry[N];

endmodule
`default_nettype wire

// File: rtl/restoring_divider8.sv
`default_nettype none
//============================================================================
// Module   : restoring_divider8
// Brief    : Iterative unsigned restoring divider behind a start/done handshake
// Revision : 1.0 - initial release
//============================================================================
module restoring_divider8
    import restoring_divider8_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int              CNT_W     = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    div_state_t       state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2*WIDTH:0] rq_shift;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] q_shift;
    logic [WIDTH:0]   trial_diff;
    logic             trial_borrow;

    // The MSB of R drops out of the shift; R never exceeds the divisor after a step.
    assign rq_shift = {r_q, q_q} << 1;
    assign r_shift  = rq_shift[2*WIDTH:WIDTH];
    assign q_shift  = rq_shift[WIDTH-1:0];

    trial_subtractor #(
        .N (WIDTH + 1)
    ) u_trial_subtractor (
        .a      (r_shift),
        .b      ({1'b0, divisor_q}),
        .diff   (trial_diff),
        .borrow (trial_borrow)
    );

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        q_d         = q_q;
        divisor_d   = divisor_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    q_d       = dividend;
                    divisor_d = divisor;
                    r_d       = '0;
                    cnt_d     = '0;
                    dbz_d     = 1'b0;
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                r_d   = trial_borrow ? r_shift : trial_diff;
                q_d   = q_shift | {{(WIDTH-1){1'b0}}, ~trial_borrow};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    quotient_d  = q_d;
                    remainder_d = r_d[WIDTH-1:0];
                    cnt_d       = '0;
                    state_d     = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            r_q         <= '0;
            q_q         <= '0;
            divisor_q   <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            q_q         <= q_d;
            divisor_q   <= divisor_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule
`default_nettype wire
